gshare_pht: RTL and testbench

Parametrised gshare pattern history table for the IF stage. It serves FETCH_WIDTH slots per fetch group, each slot with its own bank of CTR_BITS-wide saturating counters. The banks are indexed by a fold of the fetch PC, XORed with a speculative global history register (GHR). It supplies per-slot taken predictions plus a checkpoint (counter values and GHR snapshot) one cycle after lookup. It accepts resolved-branch updates from the FU, which train a counter and, on a mispredict, repair the GHR. After reset, a sequential init walk writes every counter to weak-taken before the table reports ready.

---
 rtl/gshare_pht_if.sv | 43 ++++
 rtl/gshare_pht.sv | 162 ++++++++++++++++
 tb/tb_gshare_pht.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_pht_if.sv
// gshare_pht_if: lookup, speculative-history, update and prediction signals
// of the gshare pattern history table, bundled for the IF stage.
//
//   master : fetch/FU side. Drives lk_*, spec_*, upd_*; receives predictions.
//   slave  : gshare_pht. Receives requests; drives ready_o, pred_take_o,
//            ckpt_ctr_o, ckpt_ghr_o, ghr_o.
//
// Parameters must match the gshare_pht instance that uses this interface.
interface gshare_pht_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 8
);
    logic                            ready_o;
    logic                            lk_valid_i;
    logic [31:0]                     lk_vaddr_i;
    logic [FETCH_WIDTH-1:0]          pred_take_o;
    logic [FETCH_WIDTH*CTR_BITS-1:0] ckpt_ctr_o;
    logic [GHR_BITS-1:0]             ckpt_ghr_o;
    logic                            spec_valid_i;
    logic                            spec_take_i;
    logic [GHR_BITS-1:0]             ghr_o;
    logic                            upd_valid_i;
    logic [31:0]                     upd_vaddr_i;
    logic [CTR_BITS-1:0]             upd_ctr_i;
    logic [GHR_BITS-1:0]             upd_ghr_i;
    logic                            upd_take_i;
    logic                            upd_mispred_i;

    modport master (
        input  ready_o, pred_take_o, ckpt_ctr_o, ckpt_ghr_o, ghr_o,
        output lk_valid_i, lk_vaddr_i, spec_valid_i, spec_take_i,
               upd_valid_i, upd_vaddr_i, upd_ctr_i, upd_ghr_i,
               upd_take_i, upd_mispred_i
    );

    modport slave (
        output ready_o, pred_take_o, ckpt_ctr_o, ckpt_ghr_o, ghr_o,
        input  lk_valid_i, lk_vaddr_i, spec_valid_i, spec_take_i,
               upd_valid_i, upd_vaddr_i, upd_ctr_i, upd_ghr_i,
               upd_take_i, upd_mispred_i
    );
endinterface

// File: rtl/gshare_pht.sv
// gshare_pht: gshare pattern history table for the IF stage.
//
// One bank of CTR_BITS-wide saturating counters per fetch slot. Banks are
// indexed by a fold of the fetch PC, optionally XORed with a speculative
// global history register. Lookups return per-slot predictions and a
// checkpoint (counters + GHR) one cycle later; resolved-branch updates
// train one counter and, on a mispredict, repair the GHR. After reset an
// init walk sets every counter to weak-taken before ready_o rises.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - gshare_pht_if.slave (lookup, speculative push, update, outputs)
//
// Build option:
//   PHT_GHR_HASH_EN - when defined the index is PC fold ^ GHR; otherwise the
//                     index is the PC fold only (GHR still tracked/repaired).
//
// FSM states:
//   state    | meaning
//   ST_INIT  | init walk writes weak-taken at ptr in every bank; requests ignored
//   ST_READY | lookups and updates serviced
module gshare_pht #(
    parameter int ENTRIES     = 256,
    parameter int FETCH_WIDTH = 4,
    parameter int CTR_BITS    = 2,
    parameter int GHR_BITS    = 8
) (
    input  logic          clk,
    input  logic          rst,
    gshare_pht_if.slave   bus
);
    localparam int L  = $clog2(ENTRIES);
    localparam int S  = $clog2(FETCH_WIDTH);
    localparam int O  = S + 2;
    localparam int BW = (S == 0) ? 1 : S;

    localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                          state_q, state_d;
    logic [L-1:0]                    ptr_q, ptr_d;
    logic [GHR_BITS-1:0]             ghr_q, ghr_d;
    logic [FETCH_WIDTH-1:0]          pred_q, pred_d;
    logic [FETCH_WIDTH*CTR_BITS-1:0] ckpt_ctr_q, ckpt_ctr_d;
    logic [GHR_BITS-1:0]             ckpt_ghr_q, ckpt_ghr_d;

    logic [CTR_BITS-1:0] pht_mem [FETCH_WIDTH][ENTRIES];

    logic                init_we;
    logic                upd_we;
    logic [L-1:0]        lk_idx;
    logic [L-1:0]        upd_idx;
    logic [BW-1:0]       upd_bank;
    logic [CTR_BITS-1:0] upd_ctr_new;

    // High fold shifts in zeros when it runs past bit 31.
    function automatic logic [L-1:0] fold_idx(input logic [31:0] pc,
                                              input logic [GHR_BITS-1:0] h);
        logic [L-1:0] lo;
        logic [L-1:0] hi;
        lo = L'(pc >> O);
        hi = L'(pc >> (O + L));
`ifdef PHT_GHR_HASH_EN
        return lo ^ hi ^ L'(h);
`else
        begin
            logic unused_h;
            unused_h = ^h;
        end
        return lo ^ hi;
`endif
    endfunction

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                     input logic t);
        if (t)
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        else
            return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    assign lk_idx      = fold_idx(bus.lk_vaddr_i, ghr_q);
    assign upd_idx     = fold_idx(bus.upd_vaddr_i, bus.upd_ghr_i);
    assign upd_bank    = BW'((bus.upd_vaddr_i >> 2) & 32'(FETCH_WIDTH - 1));
    assign upd_ctr_new = ctr_next(bus.upd_ctr_i, bus.upd_take_i);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pred_d     = pred_q;
        ckpt_ctr_d = ckpt_ctr_q;
        ckpt_ghr_d = ckpt_ghr_q;
        ghr_d      = ghr_q;
        init_we    = 1'b0;
        upd_we     = 1'b0;

        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                ptr_d   = ptr_q + L'(1);
                if (ptr_q == L'(ENTRIES - 1))
                    state_d = ST_READY;
            end
            ST_READY: begin
                upd_we = bus.upd_valid_i;
                if (bus.lk_valid_i) begin
                    // Reads the pre-edge table, so a same-cycle update is not seen.
                    for (int b = 0; b < FETCH_WIDTH; b++) begin
                        ckpt_ctr_d[b*CTR_BITS +: CTR_BITS] = pht_mem[b][lk_idx];
                        pred_d[b] = pht_mem[b][lk_idx][CTR_BITS-1];
                    end
                    ckpt_ghr_d = ghr_q;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // History tracking runs in both states; repair overrides a push.
        if (bus.upd_valid_i && bus.upd_mispred_i)
            ghr_d = GHR_BITS'({bus.upd_ghr_i, bus.upd_take_i});
        else if (bus.spec_valid_i)
            ghr_d = GHR_BITS'({ghr_q, bus.spec_take_i});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            ghr_q      <= '0;
            pred_q     <= '0;
            ckpt_ctr_q <= '0;
            ckpt_ghr_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ghr_q      <= ghr_d;
            pred_q     <= pred_d;
            ckpt_ctr_q <= ckpt_ctr_d;
            ckpt_ghr_q <= ckpt_ghr_d;
        end
    end

    // Table storage is not reset; the init walk establishes its contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < FETCH_WIDTH; b++) begin
            if (init_we)
                pht_mem[b][ptr_q] <= CTR_WEAK;
            else if (!rst && upd_we && upd_bank == BW'(b))
                pht_mem[b][upd_idx] <= upd_ctr_new;
        end
    end

    assign bus.ready_o     = (state_q == ST_READY);
    assign bus.pred_take_o = pred_q;
    assign bus.ckpt_ctr_o  = ckpt_ctr_q;
    assign bus.ckpt_ghr_o  = ckpt_ghr_q;
    assign bus.ghr_o       = ghr_q;

endmodule

// File: tb/tb_gshare_pht.sv
module tb_gshare_pht;
    localparam int ENTRIES = 256;
    localparam int FW      = 4;
    localparam int CB      = 2;
    localparam int GB      = 8;
    localparam int L       = 8;
    localparam int O       = 4;
    localparam int MAXC    = 3;
    localparam int WEAK    = 2;
`ifdef PHT_GHR_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_pht_if #(.FETCH_WIDTH(FW), .CTR_BITS(CB), .GHR_BITS(GB)) bus ();

    gshare_pht #(.ENTRIES(ENTRIES), .FETCH_WIDTH(FW), .CTR_BITS(CB), .GHR_BITS(GB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mdl_pht [FW][ENTRIES];
    int mdl_ckpt [FW];
    int mdl_ghr;
    int mdl_ckpt_ghr;
    bit mdl_ready;
    int mdl_init_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input longint unsigned pc, input int h);
        int lo;
        int hi;
        lo = int'((pc >> O) % ENTRIES);
        hi = int'((pc >> (O + L)) % ENTRIES);
        return lo ^ hi ^ (HASH ? h : 0);
    endfunction

    function automatic int m_ctr(input int c, input bit t);
        if (t) return (c >= MAXC) ? MAXC : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic clear_in();
        bus.lk_valid_i    = 1'b0;
        bus.lk_vaddr_i    = '0;
        bus.spec_valid_i  = 1'b0;
        bus.spec_take_i   = 1'b0;
        bus.upd_valid_i   = 1'b0;
        bus.upd_vaddr_i   = '0;
        bus.upd_ctr_i     = '0;
        bus.upd_ghr_i     = '0;
        bus.upd_take_i    = 1'b0;
        bus.upd_mispred_i = 1'b0;
    endtask

    // Advance the model with the currently driven inputs, then one clock.
    task automatic step();
        int ix;
        if (rst) begin
            mdl_ready    = 1'b0;
            mdl_init_cnt = 0;
            mdl_ghr      = 0;
            mdl_ckpt_ghr = 0;
            for (int i = 0; i < FW; i++) mdl_ckpt[i] = 0;
        end else begin
            if (mdl_ready && bus.lk_valid_i) begin
                ix = m_idx(bus.lk_vaddr_i, mdl_ghr);
                for (int i = 0; i < FW; i++) mdl_ckpt[i] = mdl_pht[i][ix];
                mdl_ckpt_ghr = mdl_ghr;
            end
            if (mdl_ready && bus.upd_valid_i)
                mdl_pht[(bus.upd_vaddr_i >> 2) % FW][m_idx(bus.upd_vaddr_i, int'(bus.upd_ghr_i))]
                    = m_ctr(int'(bus.upd_ctr_i), bus.upd_take_i);
            if (bus.upd_valid_i && bus.upd_mispred_i)
                mdl_ghr = ((int'(bus.upd_ghr_i) * 2) + int'(bus.upd_take_i)) % 256;
            else if (bus.spec_valid_i)
                mdl_ghr = ((mdl_ghr * 2) + int'(bus.spec_take_i)) % 256;
            if (!mdl_ready) begin
                mdl_init_cnt++;
                if (mdl_init_cnt == ENTRIES) begin
                    mdl_ready = 1'b1;
                    for (int b = 0; b < FW; b++)
                        for (int e = 0; e < ENTRIES; e++) mdl_pht[b][e] = WEAK;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [FW-1:0]    ep;
        logic [FW*CB-1:0] ec;
        for (int i = 0; i < FW; i++) begin
            ep[i]          = (mdl_ckpt[i] >= WEAK);
            ec[i*CB +: CB] = CB'(mdl_ckpt[i]);
        end
        chk({tag, "_ready"}, 64'(bus.ready_o), 64'(mdl_ready));
        chk({tag, "_pred"}, 64'(bus.pred_take_o), 64'(ep));
        chk({tag, "_ckpt_ctr"}, 64'(bus.ckpt_ctr_o), 64'(ec));
        chk({tag, "_ckpt_ghr"}, 64'(bus.ckpt_ghr_o), 64'(mdl_ckpt_ghr));
        chk({tag, "_ghr"}, 64'(bus.ghr_o), 64'(mdl_ghr));
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        bus.lk_valid_i = 1'b1;
        bus.lk_vaddr_i = pc;
        step();
        clear_in();
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [1:0] ctr, input bit take,
                             input logic [7:0] ghr, input bit mispred);
        bus.upd_valid_i   = 1'b1;
        bus.upd_vaddr_i   = pc;
        bus.upd_ctr_i     = ctr;
        bus.upd_take_i    = take;
        bus.upd_ghr_i     = ghr;
        bus.upd_mispred_i = mispred;
        step();
        clear_in();
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (bus.ready_o !== 1'b1 && cnt < 400) begin
            step();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'(ENTRIES));
    endtask

    initial begin
        int g;
        int ix;
        int old;
        logic [31:0] pc;

        clear_in();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_all("reset");
        chk("reset_ready_lit", 64'(bus.ready_o), 64'd0);
        chk("reset_ghr_lit", 64'(bus.ghr_o), 64'd0);

        rst = 1'b0;
        wait_ready("ready_latency");
        check_all("ready");

        do_lookup(32'h0000_0100);
        chk("init_pred", 64'(bus.pred_take_o), 64'hF);
        chk("init_ckpt", 64'(bus.ckpt_ctr_o), 64'hAA);
        check_all("init_lk");

        do_update(32'h0000_0104, 2'b10, 1'b1, 8'h00, 1'b0);
        do_lookup(32'h0000_0100);
        chk("train_ckpt", 64'(bus.ckpt_ctr_o), 64'hAE);
        check_all("train");

        do_update(32'h0000_0104, 2'b11, 1'b1, 8'h00, 1'b0);
        do_lookup(32'h0000_0100);
        chk("sat_hi_ckpt", 64'(bus.ckpt_ctr_o), 64'hAE);
        do_update(32'h0000_0108, 2'b00, 1'b0, 8'h00, 1'b0);
        do_lookup(32'h0000_0100);
        chk("sat_lo_ckpt", 64'(bus.ckpt_ctr_o), 64'h8E);
        chk("sat_lo_pred", 64'(bus.pred_take_o), 64'hB);
        check_all("sat");

        bus.spec_valid_i = 1'b1;
        bus.spec_take_i = 1'b1; step();
        bus.spec_take_i = 1'b0; step();
        bus.spec_take_i = 1'b1; step();
        clear_in();
        chk("push_ghr", 64'(bus.ghr_o), 64'h05);

        bus.spec_valid_i  = 1'b1;
        bus.spec_take_i   = 1'b1;
        bus.upd_valid_i   = 1'b1;
        bus.upd_mispred_i = 1'b1;
        bus.upd_vaddr_i   = 32'h0000_0200;
        bus.upd_ctr_i     = 2'b10;
        bus.upd_ghr_i     = 8'h3C;
        bus.upd_take_i    = 1'b0;
        step();
        clear_in();
        chk("repair_ghr", 64'(bus.ghr_o), 64'h78);
        check_all("repair");

        // Same-cycle lookup and update at one bank/index: old value first.
        g   = mdl_ghr;
        ix  = m_idx(32'h0000_0100, g);
        old = mdl_pht[1][ix];
        bus.lk_valid_i  = 1'b1;
        bus.lk_vaddr_i  = 32'h0000_0100;
        bus.upd_valid_i = 1'b1;
        bus.upd_vaddr_i = 32'h0000_0104;
        bus.upd_ctr_i   = 2'b00;
        bus.upd_take_i  = 1'b1;
        bus.upd_ghr_i   = 8'(g);
        step();
        clear_in();
        chk("rbw_old", 64'(bus.ckpt_ctr_o[3:2]), 64'(old));
        check_all("rbw");
        do_lookup(32'h0000_0100);
        chk("rbw_new", 64'(bus.ckpt_ctr_o[3:2]), 64'd1);

        for (int n = 0; n < 400; n++) begin
            bus.lk_valid_i   = 1'($urandom_range(0, 1));
            bus.lk_vaddr_i   = $urandom & 32'h0000_3FFC;
            bus.spec_valid_i = ($urandom_range(0, 3) == 0);
            bus.spec_take_i  = 1'($urandom);
            bus.upd_valid_i  = 1'($urandom_range(0, 1));
            pc = $urandom & 32'h0000_3FFC;
            bus.upd_vaddr_i  = pc;
            bus.upd_ghr_i    = ($urandom_range(0, 1) == 1) ? 8'(mdl_ghr) : 8'($urandom);
            bus.upd_ctr_i    = ($urandom_range(0, 1) == 1)
                             ? 2'(mdl_pht[(pc >> 2) % FW][m_idx(pc, int'(bus.upd_ghr_i))])
                             : 2'($urandom);
            bus.upd_take_i    = 1'($urandom);
            bus.upd_mispred_i = ($urandom_range(0, 7) == 0);
            step();
            check_all("rnd");
        end
        clear_in();

        // Reset mid-walk; history pushes still apply during the walk.
        rst = 1'b1; step();
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            bus.spec_valid_i = 1'b1;
            bus.spec_take_i  = 1'($urandom);
            bus.lk_valid_i   = 1'b1;
            bus.lk_vaddr_i   = $urandom & 32'h0000_3FFC;
            bus.upd_valid_i  = 1'b1;
            bus.upd_vaddr_i  = $urandom & 32'h0000_3FFC;
            bus.upd_ctr_i    = 2'($urandom);
            bus.upd_take_i   = 1'($urandom);
            step();
            check_all("walk");
        end
        clear_in();
        rst = 1'b1; step();
        check_all("midrst");
        chk("midrst_ghr_lit", 64'(bus.ghr_o), 64'd0);
        chk("midrst_ckpt_lit", 64'(bus.ckpt_ctr_o), 64'd0);
        rst = 1'b0;
        wait_ready("ready_latency_2");
        do_lookup(32'h0000_0100);
        chk("reinit_ckpt", 64'(bus.ckpt_ctr_o), 64'hAA);
        check_all("reinit");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
